// File: rtl/platform_manager_if.sv
// Doodle/platform bus between the physics side and the platform manager.
interface platform_manager_if #(
    parameter int unsigned NUM_BLOCKS = 8
);
    localparam int unsigned IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic          physics_tick;
    logic [31:0]   doodle_x;
    logic [31:0]   doodle_y;
    logic          doodle_falling;
    logic          has_collide;
    logic          scroll;
    logic          busy;
    logic          overrun;
    logic [31:0]   score;
    logic [IW-1:0] block_idx;
    logic [31:0]   block_x;
    logic [31:0]   block_y;

    modport master (
        output physics_tick, doodle_x, doodle_y, doodle_falling, block_idx,
        input  has_collide, scroll, busy, overrun, score, block_x, block_y
    );

    modport slave (
        input  physics_tick, doodle_x, doodle_y, doodle_falling, block_idx,
        output has_collide, scroll, busy, overrun, score, block_x, block_y
    );
endinterface

// File: rtl/platform_manager.sv
// Platform table, sequential collision scan and one-pixel world scroll.
module platform_manager #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned BLOCK_WIDTH   = 40,
    parameter int unsigned BLOCK_HEIGHT  = 8,
    parameter int unsigned NUM_BLOCKS    = 8,
    parameter int unsigned SCROLL_LINE   = 240
) (
    input logic              clk,
    input logic              reset,
    platform_manager_if.slave bus
);
    localparam int unsigned IW      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned X_RANGE = SCREEN_WIDTH - BLOCK_WIDTH + 1;
    localparam logic [IW-1:0] LAST  = IW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SCROLL} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [31:0]   dx_q;
    logic [31:0]   dy_q;
    logic          fall_q;
    logic          acc;
    logic [15:0]   lfsr;
    logic [31:0]   tbl_x [NUM_BLOCKS];
    logic [31:0]   tbl_y [NUM_BLOCKS];

    logic [31:0]   cur_x;
    logic [31:0]   cur_y;
    logic          hit_c;
    logic          fb_c;
    logic [31:0]   spawn_x_c;

    // Current-entry collision test and respawn position.
    assign cur_x     = tbl_x[idx];
    assign cur_y     = tbl_y[idx];
    assign hit_c     = fall_q
                     && (dy_q >= cur_y) && (dy_q < cur_y + 32'(BLOCK_HEIGHT))
                     && (dx_q >= cur_x) && (dx_q < cur_x + 32'(BLOCK_WIDTH));
    assign fb_c      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign spawn_x_c = {16'd0, lfsr} % 32'(X_RANGE);

    // Render read port, zero latency.
    assign bus.block_x = tbl_x[bus.block_idx];
    assign bus.block_y = tbl_y[bus.block_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.physics_tick) state_nxt = SCAN;
            end
            SCAN: begin
                if (idx == LAST) state_nxt = (dy_q > 32'(SCROLL_LINE)) ? SCROLL : IDLE;
            end
            SCROLL: begin
                if (idx == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy decodes directly from the state register.
    always_comb begin
        bus.busy = 1'b0;
        if (state != IDLE) bus.busy = 1'b1;
    end

    // Datapath: latches, scan accumulator, table updates, score and LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr            <= 16'hACE1;
            bus.has_collide <= 1'b0;
            bus.scroll      <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.score       <= 32'd0;
            acc             <= 1'b0;
            idx             <= '0;
            dx_q            <= 32'd0;
            dy_q            <= 32'd0;
            fall_q          <= 1'b0;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                tbl_y[i] <= 32'(i * (SCREEN_HEIGHT / NUM_BLOCKS));
                tbl_x[i] <= 32'(((SCREEN_WIDTH - BLOCK_WIDTH) / 2 + i * 2 * BLOCK_WIDTH) % X_RANGE);
            end
        end else begin
            lfsr       <= {lfsr[14:0], fb_c};
            bus.scroll <= 1'b0;
            if (bus.physics_tick && (state != IDLE)) bus.overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.physics_tick) begin
                        dx_q   <= bus.doodle_x;
                        dy_q   <= bus.doodle_y;
                        fall_q <= bus.doodle_falling;
                        acc    <= 1'b0;
                        idx    <= '0;
                    end
                end
                SCAN: begin
                    acc <= acc | hit_c;
                    idx <= idx + IW'(1);
                    if (idx == LAST) begin
                        bus.has_collide <= acc | hit_c;
                        idx             <= '0;
                    end
                end
                SCROLL: begin
                    if (cur_y == 32'd0) begin
                        tbl_y[idx] <= 32'(SCREEN_HEIGHT - 1);
                        tbl_x[idx] <= spawn_x_c;
                    end else begin
                        tbl_y[idx] <= cur_y - 32'd1;
                    end
                    idx <= idx + IW'(1);
                    if (idx == LAST) begin
                        bus.score  <= bus.score + 32'd1;
                        bus.scroll <= 1'b1;
                        idx        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_platform_manager.sv
// Directed checks of the platform manager with default parameters.
module tb_platform_manager;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    platform_manager_if #(.NUM_BLOCKS(8)) bus ();

    platform_manager dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        f;
        logic        exp;
        string       name;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] init_x [8];
    logic [31:0] init_y [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Drive a one-cycle tick; returns just after the tick edge (edge 0).
    task automatic tick(input logic [31:0] x, input logic [31:0] y, input logic f);
        @(negedge clk);
        bus.doodle_x       = x;
        bus.doodle_y       = y;
        bus.doodle_falling = f;
        bus.physics_tick   = 1'b1;
        @(negedge clk);
        bus.physics_tick   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_block(input int i, output logic [31:0] x, output logic [31:0] y);
        bus.block_idx = 3'(i);
        #1;
        x = bus.block_x;
        y = bus.block_y;
    endtask

    task automatic check_layout(input string tag);
        logic [31:0] bx, by;
        for (int i = 0; i < 8; i++) begin
            read_block(i, bx, by);
            check($sformatf("%s_x%0d", tag, i), bx, init_x[i]);
            check($sformatf("%s_y%0d", tag, i), by, init_y[i]);
        end
    endtask

    initial begin
        logic [31:0] bx, by;
        int          busy_cnt;
        int          scroll_cnt;

        init_x = '{32'd140, 32'd220, 32'd19, 32'd99, 32'd179, 32'd259, 32'd58, 32'd138};
        init_y = '{32'd0, 32'd60, 32'd120, 32'd180, 32'd240, 32'd300, 32'd360, 32'd420};

        vecs[0]  = '{32'd160, 32'd4,   1'b1, 1'b1, "hit_b0"};
        vecs[1]  = '{32'd160, 32'd4,   1'b0, 1'b0, "rising"};
        vecs[2]  = '{32'd179, 32'd4,   1'b1, 1'b1, "x_last_in"};
        vecs[3]  = '{32'd180, 32'd4,   1'b1, 1'b0, "x_first_out"};
        vecs[4]  = '{32'd160, 32'd8,   1'b1, 1'b0, "y_first_out"};
        vecs[5]  = '{32'd140, 32'd0,   1'b1, 1'b1, "corner_b0"};
        vecs[6]  = '{32'd139, 32'd0,   1'b1, 1'b0, "x_left_out"};
        vecs[7]  = '{32'd220, 32'd60,  1'b1, 1'b1, "hit_b1"};
        vecs[8]  = '{32'd19,  32'd127, 1'b1, 1'b1, "hit_b2_ylast"};
        vecs[9]  = '{32'd19,  32'd128, 1'b1, 1'b0, "b2_y_out"};
        vecs[10] = '{32'd179, 32'd240, 1'b1, 1'b1, "hit_b4_scrollline"};
        vecs[11] = '{32'd300, 32'd100, 1'b1, 1'b0, "miss"};

        bus.physics_tick   = 1'b0;
        bus.doodle_x       = 32'd0;
        bus.doodle_y       = 32'd0;
        bus.doodle_falling = 1'b0;
        bus.block_idx      = 3'd0;

        cycles(2);
        reset = 1'b0;

        // Reset state.
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_collide", 32'(bus.has_collide), 32'd0);
        check("rst_scroll", 32'(bus.scroll), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_score", bus.score, 32'd0);
        check_layout("rst");

        // Scan-only vectors against the reset layout.
        for (int v = 0; v < 12; v++) begin
            scroll_cnt = 0;
            tick(vecs[v].x, vecs[v].y, vecs[v].f);
            for (int e = 1; e <= 8; e++) begin
                cycles(1);
                if (bus.scroll) scroll_cnt++;
            end
            check(vecs[v].name, 32'(bus.has_collide), 32'(vecs[v].exp));
            check({vecs[v].name, "_idle"}, 32'(bus.busy), 32'd0);
            check({vecs[v].name, "_noscroll"}, 32'(scroll_cnt), 32'd0);
        end

        // Landing timing: busy for 8 cycles, flag loads exactly on edge 8.
        busy_cnt = 0;
        scroll_cnt = 0;
        tick(32'd160, 32'd4, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            if (bus.busy) busy_cnt++;
            if (e == 8) check("land_prev_flag", 32'(bus.has_collide), 32'd0);
            cycles(1);
            if (bus.scroll) scroll_cnt++;
        end
        check("land_busy_cycles", 32'(busy_cnt), 32'd8);
        check("land_flag", 32'(bus.has_collide), 32'd1);
        check("land_busy_end", 32'(bus.busy), 32'd0);
        check("land_noscroll", 32'(scroll_cnt), 32'd0);
        cycles(5);
        check("land_hold", 32'(bus.has_collide), 32'd1);

        // Overrun: second tick on edge 3 is dropped.
        tick(32'd160, 32'd4, 1'b0);
        cycles(2);
        bus.doodle_falling = 1'b1;
        bus.physics_tick   = 1'b1;
        cycles(1);
        bus.physics_tick   = 1'b0;
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        cycles(5);
        check("ovr_collide", 32'(bus.has_collide), 32'd0);
        check("ovr_idle", 32'(bus.busy), 32'd0);
        cycles(12);
        check("ovr_one_scan", 32'(bus.has_collide), 32'd0);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Scroll pass.
        do_reset();
        check("rst2_overrun", 32'(bus.overrun), 32'd0);
        scroll_cnt = 0;
        tick(32'd160, 32'd241, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            cycles(1);
            if (bus.scroll) scroll_cnt++;
        end
        check("scr_early", 32'(scroll_cnt), 32'd0);
        check("scr_busy15", 32'(bus.busy), 32'd1);
        check("scr_score15", bus.score, 32'd0);
        cycles(1);
        check("scr_pulse", 32'(bus.scroll), 32'd1);
        check("scr_score", bus.score, 32'd1);
        check("scr_busy16", 32'(bus.busy), 32'd0);
        check("scr_collide", 32'(bus.has_collide), 32'd0);
        cycles(1);
        check("scr_pulse_end", 32'(bus.scroll), 32'd0);
        read_block(0, bx, by);
        check("scr_b0_y", by, 32'd479);
        check("scr_b0_x_range", 32'(bx <= 32'd280), 32'd1);
        read_block(1, bx, by);
        check("scr_b1_x", bx, 32'd220);
        check("scr_b1_y", by, 32'd59);
        read_block(7, bx, by);
        check("scr_b7_y", by, 32'd419);
        tick(32'd220, 32'd59, 1'b1);
        cycles(8);
        check("scr_hit_moved_b1", 32'(bus.has_collide), 32'd1);

        // Reset in the middle of a scan, with overrun set.
        tick(32'd220, 32'd59, 1'b1);
        cycles(1);
        bus.physics_tick = 1'b1;
        cycles(1);
        bus.physics_tick = 1'b0;
        check("mid_overrun_set", 32'(bus.overrun), 32'd1);
        cycles(1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_collide", 32'(bus.has_collide), 32'd0);
        check("mid_score", bus.score, 32'd0);
        check("mid_overrun", 32'(bus.overrun), 32'd0);
        check_layout("mid");
        cycles(10);
        check("mid_stay_idle", 32'(bus.busy), 32'd0);
        check("mid_no_collide", 32'(bus.has_collide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/platform_manager.md
PLATFORM_MANAGER -- requirements
Module: platform_manager

Interface
REQ-001 SHALL have parameters (name, default, meaning): SCREEN_WIDTH 320, screen width in px; SCREEN_HEIGHT 480, screen height in px; BLOCK_WIDTH 40, platform width; BLOCK_HEIGHT 8, platform height; NUM_BLOCKS 8, platform count (power of 2); SCROLL_LINE 240, doodle Y above which the world scrolls.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, reset (synchronous, active-high)
- physics_tick, in, 1, one-cycle pulse starting an update
- doodle_x, in, 32, doodle foot X
- doodle_y, in, 32, doodle foot Y
- doodle_falling, in, 1, doodle moving down
- has_collide, out, 1, registered landing flag
- scroll, out, 1, one-cycle pulse: world moved down 1 px
- busy, out, 1, update in progress
- overrun, out, 1, sticky: tick dropped
- score, out, 32, scroll count
- block_idx, in, log2(NUM_BLOCKS), render read index
- block_x, out, 32, X of block block_idx
- block_y, out, 32, Y of block block_idx

Function
REQ-003 SHALL hold a NUM_BLOCKS-entry table of (x, y), each 32-bit unsigned.
REQ-004 block_x/block_y SHALL be combinational reads of the table at block_idx, zero latency.
REQ-005 FSM states SHALL be IDLE, SCAN, SCROLL; busy=1 in SCAN and SCROLL.
REQ-006 IDLE: physics_tick=1 at an edge SHALL latch doodle_x, doodle_y, doodle_falling, clear the hit accumulator, set index=0 and enter SCAN.
REQ-007 SCAN: each cycle SHALL test one block (index 0..NUM_BLOCKS-1) and OR the result into the hit accumulator.
REQ-008 Hit SHALL be: latched falling=1 AND y_i <= dy < y_i+BLOCK_HEIGHT AND x_i <= dx < x_i+BLOCK_WIDTH, 32-bit unsigned compare.
REQ-009 At the edge testing the last block, has_collide SHALL load the final accumulator value, NUM_BLOCKS edges after the tick edge. It SHALL hold until the next scan completes.
REQ-010 After SCAN, the FSM SHALL enter SCROLL with index=0 if latched dy > SCROLL_LINE, else IDLE.
REQ-011 SCROLL: each cycle SHALL update one block. If y_i==0, the block respawns with y_i=SCREEN_HEIGHT-1 and x_i = lfsr mod (SCREEN_WIDTH-BLOCK_WIDTH+1). Otherwise y_i decrements by 1.
REQ-012 On the edge processing the last block, the block SHALL increment score (wrap at 2^32) and assert scroll for exactly the following cycle, then return to IDLE.
REQ-013 physics_tick while busy=1 SHALL be ignored and SHALL set overrun=1 until reset.
REQ-014 The block SHALL contain a 16-bit Fibonacci LFSR, taps 16,14,13,11, that advances every clk cycle and never reaches all-zero.
REQ-015 has_collide SHALL NOT change in IDLE or SCROLL.

Reset
REQ-016 When reset=1 at an edge, the block SHALL enter IDLE and clear has_collide, scroll, busy, overrun, score and the hit accumulator, and set lfsr=16'hACE1. This takes priority over physics_tick and any state, including mid-SCAN or mid-SCROLL.
REQ-017 Reset SHALL load the table with y_i = i*(SCREEN_HEIGHT/NUM_BLOCKS) and x_i = ((SCREEN_WIDTH-BLOCK_WIDTH)/2 + i*2*BLOCK_WIDTH) mod (SCREEN_WIDTH-BLOCK_WIDTH+1). With defaults: block0=(140,0), block1=(220,60), block2=(19,120).

Verification (defaults)
REQ-018 Landing hit: reset, then tick with (160,4) and falling=1 -> busy for 8 cycles, has_collide=1 8 edges after the tick, no scroll.
REQ-019 Direction gating: tick with (160,4) and falling=0 -> has_collide=0. X boundary: (179,4) falling -> 1; (180,4) -> 0. Y boundary: (160,8) falling -> 0.
REQ-020 Scroll: tick with (160,241) and falling=0 -> scroll pulse 16 edges after the tick, score=1, block1 y=59, block0 respawned at y=479 with x in 0..280.
REQ-021 Overrun: a second tick 3 cycles after the first -> overrun=1, only one scan performed, has_collide reflects the first tick only.
REQ-022 Reset mid-SCAN at cycle 4 -> next cycle busy=0, has_collide=0, table equals the REQ-017 layout, score=0, overrun=0.
